// File: rtl/complex_div_seq.sv
// complex_div_seq: sequential complex divider q = num/den.
// q = ((ac+bd) + j(bc-ad)) / (c^2+d^2), with num = a+jb and den = c+jd.
// The divider handles one operation at a time and has a fixed latency.
// The quotient has FRAC fractional bits. Each magnitude is truncated toward
// zero, and the sign is applied afterwards.
//
// Handshake rules (valid/ready):
//   A transfer happens on a rising edge where valid and ready are both high.
//   in_ready is high only in IDLE. Once out_valid rises, the result holds it
//   and keeps q_*/flags stable until out_ready is seen.
module complex_div_seq #(
  parameter int inWordWidth_1 = 18,
  parameter int inWordWidth_2 = 20,
  parameter int QW            = 18,
  parameter int FRAC          = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [inWordWidth_1-1:0] num_real,
  input  logic signed [inWordWidth_1-1:0] num_imag,
  input  logic signed [inWordWidth_2-1:0] den_real,
  input  logic signed [inWordWidth_2-1:0] den_imag,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [QW-1:0]            q_real,
  output logic signed [QW-1:0]            q_imag,
  output logic                            div_by_zero,
  output logic                            saturated
);

  localparam int W1   = inWordWidth_1;
  localparam int W2   = inWordWidth_2;
  localparam int PW   = W1 + W2 + 1;      // cross-product sums
  localparam int MW   = 2 * W2 + 1;       // |den|^2
  localparam int DW   = PW + FRAC;        // scaled dividend / remainder
  localparam int SW   = MW + QW - 2;      // divisor aligned to quotient MSB
  localparam int CW   = MW + QW - 1;      // common compare width
  localparam int NW   = QW - 1;           // quotient magnitude bits
  localparam int CNTW = $clog2(QW - 1);

  localparam logic signed [QW-1:0] QMAX = {1'b0, {(QW-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, MULT, PREP, DIV, DONE} state_t;

  state_t state, state_n;

  logic signed [W1-1:0] a_r, b_r;
  logic signed [W2-1:0] c_r, d_r;
  logic signed [PW-1:0] pr, pi;
  logic        [MW-1:0] mag;
  logic        [DW-1:0] rem_re, rem_im;
  logic        [SW-1:0] dsr;
  logic        [NW-1:0] qm_re, qm_im;
  logic      [CNTW-1:0] cnt;
  logic                 ovf_re, ovf_im, dbz, neg_re, neg_im;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Cross products. Operands are sign-extended to full width so nothing is truncated.
  logic signed [PW-1:0] ax, bx, cx, dx, pr_n, pi_n;
  logic signed [MW-1:0] cm, dm, mag_s;
  assign ax    = PW'(a_r);
  assign bx    = PW'(b_r);
  assign cx    = PW'(c_r);
  assign dx    = PW'(d_r);
  assign pr_n  = ax * cx + bx * dx;
  assign pi_n  = bx * cx - ax * dx;
  assign cm    = MW'(c_r);
  assign dm    = MW'(d_r);
  assign mag_s = cm * cm + dm * dm;

  // Magnitudes, scaled dividends and overflow detection for the PREP step.
  logic [PW-1:0] pr_abs, pi_abs;
  logic [DW-1:0] dvd_re, dvd_im;
  logic [CW-1:0] mag_lim;
  assign pr_abs  = pr[PW-1] ? -pr : pr;
  assign pi_abs  = pi[PW-1] ? -pi : pi;
  assign dvd_re  = {pr_abs, {FRAC{1'b0}}};
  assign dvd_im  = {pi_abs, {FRAC{1'b0}}};
  assign mag_lim = {mag, {(QW-1){1'b0}}};

  // One restoring step per component. Both components share the shifting divisor.
  logic          ge_re, ge_im;
  logic [DW-1:0] sub_re, sub_im;
  logic [NW-1:0] qm_re_n, qm_im_n;
  assign ge_re   = CW'(rem_re) >= CW'(dsr);
  assign ge_im   = CW'(rem_im) >= CW'(dsr);
  assign sub_re  = DW'(CW'(rem_re) - CW'(dsr));
  assign sub_im  = DW'(CW'(rem_im) - CW'(dsr));
  assign qm_re_n = {qm_re[NW-2:0], ge_re};
  assign qm_im_n = {qm_im[NW-2:0], ge_im};

  // Final signed component. Divide-by-zero wins over saturation.
  function automatic logic signed [QW-1:0] finish_q(input logic dz, input logic ovf,
                                                    input logic neg, input logic [NW-1:0] m);
    logic signed [QW-1:0] v;
    if (dz)       v = '0;
    else if (ovf) v = neg ? -QMAX : QMAX;
    else          v = neg ? -QW'(m) : QW'(m);
    return v;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = MULT;
      MULT:    state_n = PREP;
      PREP:    state_n = DIV;
      DIV:     if (cnt == '0) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: capture operands, multiply, prepare, divide, then register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      c_r         <= '0;
      d_r         <= '0;
      pr          <= '0;
      pi          <= '0;
      mag         <= '0;
      rem_re      <= '0;
      rem_im      <= '0;
      dsr         <= '0;
      qm_re       <= '0;
      qm_im       <= '0;
      cnt         <= '0;
      ovf_re      <= 1'b0;
      ovf_im      <= 1'b0;
      dbz         <= 1'b0;
      neg_re      <= 1'b0;
      neg_im      <= 1'b0;
      q_real      <= '0;
      q_imag      <= '0;
      div_by_zero <= 1'b0;
      saturated   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= num_real;
            b_r <= num_imag;
            c_r <= den_real;
            d_r <= den_imag;
          end
        end
        MULT: begin
          pr  <= pr_n;
          pi  <= pi_n;
          mag <= MW'(mag_s);
        end
        PREP: begin
          rem_re <= dvd_re;
          rem_im <= dvd_im;
          dsr    <= {mag, {(QW-2){1'b0}}};
          ovf_re <= CW'(dvd_re) >= mag_lim;
          ovf_im <= CW'(dvd_im) >= mag_lim;
          dbz    <= (mag == '0);
          neg_re <= pr[PW-1];
          neg_im <= pi[PW-1];
          qm_re  <= '0;
          qm_im  <= '0;
          cnt    <= CNTW'(QW - 2);
        end
        DIV: begin
          if (ge_re) rem_re <= sub_re;
          if (ge_im) rem_im <= sub_im;
          qm_re <= qm_re_n;
          qm_im <= qm_im_n;
          dsr   <= dsr >> 1;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            q_real      <= finish_q(dbz, ovf_re, neg_re, qm_re_n);
            q_imag      <= finish_q(dbz, ovf_im, neg_im, qm_im_n);
            div_by_zero <= dbz;
            saturated   <= (ovf_re | ovf_im) & ~dbz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
